// File: rtl/zx_ps2_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// zx_ps2_scan_decoder_if
// Bundles the PS/2 keyboard lines and the key-command outputs of the scan
// decoder.
//   ps2_clk   : PS/2 clock line (raw, asynchronous)
//   ps2_dat   : PS/2 data line (raw, asynchronous)
//   key_num   : ZX key index of the last command, 0..41
//   key_rel   : 1 = released, 0 = pressed
//   key_stb   : one-cycle command strobe
//   frame_err : one-cycle frame error pulse
// The master modport is the keyboard / environment side. The slave modport is
// the decoder side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface zx_ps2_scan_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [5:0] key_num;
    logic       key_rel;
    logic       key_stb;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_dat,
        input  key_num,
        input  key_rel,
        input  key_stb,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output key_num,
        output key_rel,
        output key_stb,
        output frame_err
    );
endinterface

// File: rtl/zx_ps2_scan_decoder.sv
// -----------------------------------------------------------------------------
// zx_ps2_scan_decoder
// Receives raw PS/2 keyboard frames and assembles scan-code set 2 sequences
// (E0 / F0 / E1 prefixes). Each make or break of a mapped key becomes a key
// command: a ZX matrix index (0..39 matrix, 40 magic, 41 Z80 reset) plus a
// released flag, issued as a one-cycle strobe.
// Ports:
//   clk_50M : system clock
//   rst_i   : asynchronous active-low reset
//   kbd     : slave side of zx_ps2_scan_decoder_if
//             (ps2_clk/ps2_dat in; key_num/key_rel/key_stb/frame_err out)
// Parameters:
//   FILTER_LEN  : stable synchronised samples needed before a line may change
//   TIMEOUT_CYC : idle cycles allowed between clock edges inside a frame
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module zx_ps2_scan_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk_50M,
    input  logic                   rst_i,
    zx_ps2_scan_decoder_if.slave   kbd
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Odd parity: the eight data bits and the parity bit XOR to 1.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Translate {ext, set-2 make code} into {valid, ZX index}.
    // ZX index = half-row + 8 * key position within the half-row.
    function automatic logic [6:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [6:0] res;
        res = 7'd0;
        if (ext) begin
            case (code)
                8'h5A:   res = {1'b1, 6'd6};    // keypad Enter
                default: res = 7'd0;
            endcase
        end else begin
            case (code)
                // CS Z X C V
                8'h12:   res = {1'b1, 6'd0};
                8'h1A:   res = {1'b1, 6'd8};
                8'h22:   res = {1'b1, 6'd16};
                8'h21:   res = {1'b1, 6'd24};
                8'h2A:   res = {1'b1, 6'd32};
                // A S D F G
                8'h1C:   res = {1'b1, 6'd1};
                8'h1B:   res = {1'b1, 6'd9};
                8'h23:   res = {1'b1, 6'd17};
                8'h2B:   res = {1'b1, 6'd25};
                8'h34:   res = {1'b1, 6'd33};
                // Q W E R T
                8'h15:   res = {1'b1, 6'd2};
                8'h1D:   res = {1'b1, 6'd10};
                8'h24:   res = {1'b1, 6'd18};
                8'h2D:   res = {1'b1, 6'd26};
                8'h2C:   res = {1'b1, 6'd34};
                // 1 2 3 4 5
                8'h16:   res = {1'b1, 6'd3};
                8'h1E:   res = {1'b1, 6'd11};
                8'h26:   res = {1'b1, 6'd19};
                8'h25:   res = {1'b1, 6'd27};
                8'h2E:   res = {1'b1, 6'd35};
                // 0 9 8 7 6
                8'h45:   res = {1'b1, 6'd4};
                8'h46:   res = {1'b1, 6'd12};
                8'h3E:   res = {1'b1, 6'd20};
                8'h3D:   res = {1'b1, 6'd28};
                8'h36:   res = {1'b1, 6'd36};
                // P O I U Y
                8'h4D:   res = {1'b1, 6'd5};
                8'h44:   res = {1'b1, 6'd13};
                8'h43:   res = {1'b1, 6'd21};
                8'h3C:   res = {1'b1, 6'd29};
                8'h35:   res = {1'b1, 6'd37};
                // Enter L K J H
                8'h5A:   res = {1'b1, 6'd6};
                8'h4B:   res = {1'b1, 6'd14};
                8'h42:   res = {1'b1, 6'd22};
                8'h3B:   res = {1'b1, 6'd30};
                8'h33:   res = {1'b1, 6'd38};
                // Space SS M N B (both right shift and left ctrl act as SS)
                8'h29:   res = {1'b1, 6'd7};
                8'h59:   res = {1'b1, 6'd15};
                8'h14:   res = {1'b1, 6'd15};
                8'h3A:   res = {1'b1, 6'd23};
                8'h31:   res = {1'b1, 6'd31};
                8'h32:   res = {1'b1, 6'd39};
                // F12 -> magic, F10 -> Z80 reset
                8'h07:   res = {1'b1, 6'd40};
                8'h09:   res = {1'b1, 6'd41};
                default: res = 7'd0;
            endcase
        end
        return res;
    endfunction

    // Line conditioning: bit 0 is the PS/2 clock, bit 1 the PS/2 data.
    logic [1:0]     raw_s;
    logic [1:0]     sync1_r;
    logic [1:0]     sync2_r;
    logic [1:0]     filt_r;
    logic [FCW-1:0] filt_cnt_r [2];
    logic           clk_filt_d_r;
    logic           edge_s;
    logic           dat_s;

    // Frame receiver state.
    frame_state_t   state_r;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic           par_ok_r;
    logic [TCW-1:0] tmo_cnt_r;
    logic           byte_stb_r;
    logic [7:0]     byte_r;
    logic           frame_err_r;

    // Sequence decoder state and outputs.
    logic           ext_r;
    logic           brk_r;
    logic [2:0]     skip_r;
    logic [6:0]     lookup_s;
    logic [5:0]     key_num_r;
    logic           key_rel_r;
    logic           key_stb_r;

    assign raw_s    = {kbd.ps2_dat, kbd.ps2_clk};
    assign edge_s   = clk_filt_d_r & ~filt_r[0];
    assign dat_s    = filt_r[1];
    assign lookup_s = key_lookup(ext_r, byte_r);

    assign kbd.key_num   = key_num_r;
    assign kbd.key_rel   = key_rel_r;
    assign kbd.key_stb   = key_stb_r;
    assign kbd.frame_err = frame_err_r;

    // Two-flop synchronisers and stability filters for both PS/2 lines.
    // Idle level of both lines is high, so everything resets to 1.
    always_ff @(posedge clk_50M or negedge rst_i) begin
        if (!rst_i) begin
            sync1_r      <= 2'b11;
            sync2_r      <= 2'b11;
            filt_r       <= 2'b11;
            clk_filt_d_r <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                filt_cnt_r[i] <= FCW'(0);
            end
        end else begin
            sync1_r      <= raw_s;
            sync2_r      <= sync1_r;
            clk_filt_d_r <= filt_r[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    filt_cnt_r[i] <= FCW'(0);
                end else if (filt_cnt_r[i] == FCW'(FILTER_LEN - 1)) begin
                    // FILTER_LEN consecutive differing samples: accept new level.
                    filt_r[i]     <= sync2_r[i];
                    filt_cnt_r[i] <= FCW'(0);
                end else begin
                    filt_cnt_r[i] <= filt_cnt_r[i] + FCW'(1);
                end
            end
        end
    end

    // Frame state machine: start, 8 data bits LSB first, odd parity, stop,
    // with an inter-edge timeout while a frame is in progress.
    always_ff @(posedge clk_50M or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            par_ok_r    <= 1'b0;
            tmo_cnt_r   <= TCW'(0);
            byte_stb_r  <= 1'b0;
            byte_r      <= 8'd0;
            frame_err_r <= 1'b0;
        end else begin
            byte_stb_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tmo_cnt_r <= TCW'(0);
                    bit_cnt_r <= 3'd0;
                    if (edge_s) begin
                        if (!dat_s) begin
                            state_r <= ST_DATA;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    if (edge_s) begin
                        tmo_cnt_r <= TCW'(0);
                        case (state_r)
                            ST_DATA: begin
                                shift_r   <= {dat_s, shift_r[7:1]};
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                if (bit_cnt_r == 3'd7) begin
                                    state_r <= ST_PARITY;
                                end else begin
                                    state_r <= ST_DATA;
                                end
                            end
                            ST_PARITY: begin
                                par_ok_r <= odd_parity_ok(shift_r, dat_s);
                                state_r  <= ST_STOP;
                            end
                            ST_STOP: begin
                                if (dat_s && par_ok_r) begin
                                    byte_stb_r <= 1'b1;
                                    byte_r     <= shift_r;
                                end else begin
                                    frame_err_r <= 1'b1;
                                end
                                state_r <= ST_IDLE;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else if (tmo_cnt_r == TCW'(TIMEOUT_CYC - 1)) begin
                        // Keyboard stopped clocking mid-frame: abandon it.
                        frame_err_r <= 1'b1;
                        tmo_cnt_r   <= TCW'(0);
                        state_r     <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TCW'(1);
                    end
                end
            endcase
        end
    end

    // Sequence decoder: tracks E0/F0 prefixes, swallows the 8-byte Pause
    // sequence and emits a key command for every mapped make/break code.
    always_ff @(posedge clk_50M or negedge rst_i) begin
        if (!rst_i) begin
            ext_r     <= 1'b0;
            brk_r     <= 1'b0;
            skip_r    <= 3'd0;
            key_num_r <= 6'd0;
            key_rel_r <= 1'b1;
            key_stb_r <= 1'b0;
        end else begin
            key_stb_r <= 1'b0;
            if (frame_err_r) begin
                ext_r  <= 1'b0;
                brk_r  <= 1'b0;
                skip_r <= 3'd0;
            end else if (byte_stb_r) begin
                if (skip_r != 3'd0) begin
                    skip_r <= skip_r - 3'd1;
                    ext_r  <= 1'b0;
                    brk_r  <= 1'b0;
                end else begin
                    case (byte_r)
                        8'hE0: begin
                            ext_r <= 1'b1;
                        end
                        8'hF0: begin
                            brk_r <= 1'b1;
                        end
                        8'hE1: begin
                            // Pause: E1 plus seven more bytes, all ignored.
                            skip_r <= 3'd7;
                            ext_r  <= 1'b0;
                            brk_r  <= 1'b0;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                            // Keyboard status / acknowledge bytes.
                            ext_r <= 1'b0;
                            brk_r <= 1'b0;
                        end
                        default: begin
                            if (lookup_s[6]) begin
                                key_stb_r <= 1'b1;
                                key_num_r <= lookup_s[5:0];
                                key_rel_r <= brk_r;
                            end else begin
                                key_stb_r <= 1'b0;
                            end
                            ext_r <= 1'b0;
                            brk_r <= 1'b0;
                        end
                    endcase
                end
            end else begin
                skip_r <= skip_r;
            end
        end
    end

endmodule

// File: tb/tb_zx_ps2_scan_decoder.sv
`timescale 1ns/1ps
module tb_zx_ps2_scan_decoder;

    localparam int HALF = 16;    // PS/2 half bit period in system clocks
    localparam int TMO  = 300;   // shortened frame timeout for simulation

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #10 clk = ~clk;

    zx_ps2_scan_decoder_if bus ();

    zx_ps2_scan_decoder #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_50M(clk),
        .rst_i  (rst_i),
        .kbd    (bus)
    );

    int checks = 0;
    int errors = 0;
    int strobe_q[$];   // each entry: key_rel * 64 + key_num
    int ferr_cnt = 0;

    // ZX matrix layout: row r, position c -> index r + 8*c.
    logic [7:0] zx_rows [8][5] = '{
        '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},   // CS Z X C V
        '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},   // A S D F G
        '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},   // Q W E R T
        '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},   // 1 2 3 4 5
        '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},   // 0 9 8 7 6
        '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},   // P O I U Y
        '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},   // Enter L K J H
        '{8'h29, 8'h59, 8'h3A, 8'h31, 8'h32}    // Space SS M N B
    };

    function automatic int zx_index(input bit ext, input logic [7:0] code);
        if (ext) return (code == 8'h5A) ? 6 : -1;
        if (code == 8'h14) return 15;
        if (code == 8'h07) return 40;
        if (code == 8'h09) return 41;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (zx_rows[r][c] == code) return r + 8 * c;
        return -1;
    endfunction

    function automatic bit is_special(input logic [7:0] code);
        return code inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction

    // Capture every strobe and error pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.key_stb === 1'b1) strobe_q.push_back(int'(bus.key_rel) * 64 + int'(bus.key_num));
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_obs();
        strobe_q.delete();
        ferr_cnt = 0;
    endtask

    // One PS/2 bit; optionally a short low glitch on the clock before the real edge.
    task automatic ps2_bit(input bit b, input bit glitch);
        bus.ps2_dat = b;
        if (glitch) begin
            wait_cyc(4);
            bus.ps2_clk = 1'b0;
            wait_cyc(4);
            bus.ps2_clk = 1'b1;
            wait_cyc(HALF - 8);
        end else begin
            wait_cyc(HALF);
        end
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ flip_par, glitch);
        ps2_bit(1'b1, glitch);
        bus.ps2_dat = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    // A whole key event; the expectation comes from the key map alone.
    task automatic key_event(input bit ext, input bit brk, input logic [7:0] code, input string tag);
        int exp;
        clear_obs();
        if (ext) send_frame(8'hE0, 1'b0, 1'b0);
        if (brk) send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(code, 1'b0, 1'b0);
        exp = zx_index(ext, code);
        check({tag, "_cnt"}, strobe_q.size(), (exp >= 0) ? 1 : 0);
        check({tag, "_ferr"}, ferr_cnt, 0);
        if (exp >= 0) begin
            check({tag, "_num"}, (strobe_q.size() > 0) ? strobe_q[0] % 64 : -1, exp);
            check({tag, "_rel"}, (strobe_q.size() > 0) ? strobe_q[0] / 64 : -1, int'(brk));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_num"}, int'(bus.key_num), 0);
        check({tag, "_rel"}, int'(bus.key_rel), 1);
        check({tag, "_stb"}, int'(bus.key_stb), 0);
        check({tag, "_ferr"}, int'(bus.frame_err), 0);
    endtask

    initial begin
        logic [7:0] code;
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] part;
        bit ext, brk;

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        rst_i = 1'b0;
        wait_cyc(5);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b1;
        wait_cyc(20);

        // Basic make and break of Z.
        key_event(1'b0, 1'b0, 8'h1A, "z_make");
        key_event(1'b0, 1'b1, 8'h1A, "z_break");

        // Parity error, then the same code cleanly.
        clear_obs();
        send_frame(8'h1C, 1'b1, 1'b0);
        check("par_ferr", ferr_cnt, 1);
        check("par_stb", strobe_q.size(), 0);
        key_event(1'b0, 1'b0, 8'h1C, "a_after_par");

        // Timeout after 4 data bits.
        clear_obs();
        part = 8'h5A;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i], 1'b0);
        bus.ps2_dat = 1'b1;
        wait_cyc(TMO + 100);
        check("tmo_ferr", ferr_cnt, 1);
        check("tmo_stb", strobe_q.size(), 0);
        key_event(1'b0, 1'b0, 8'h07, "f12_after_tmo");

        // Pause sequence is swallowed, the next byte decodes normally.
        clear_obs();
        foreach (pause_seq[i]) send_frame(pause_seq[i], 1'b0, 1'b0);
        check("pause_stb", strobe_q.size(), 0);
        check("pause_ferr", ferr_cnt, 0);
        key_event(1'b0, 1'b0, 8'h09, "f10_after_pause");

        // Extended and alias keys.
        key_event(1'b1, 1'b0, 8'h5A, "ext_enter");
        key_event(1'b1, 1'b0, 8'h12, "ext_unmapped");
        key_event(1'b0, 1'b0, 8'h59, "rshift");
        key_event(1'b0, 1'b1, 8'h14, "lctrl_break");

        // A status byte between F0 and a code cancels the break.
        clear_obs();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h1A, 1'b0, 1'b0);
        check("aa_cnt", strobe_q.size(), 1);
        check("aa_num", (strobe_q.size() > 0) ? strobe_q[0] % 64 : -1, 8);
        check("aa_rel", (strobe_q.size() > 0) ? strobe_q[0] / 64 : -1, 0);

        // Short clock glitches while idle and inside every bit of a frame.
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            bus.ps2_clk = 1'b0;
            wait_cyc(5);
            bus.ps2_clk = 1'b1;
            wait_cyc(20);
        end
        send_frame(8'h4D, 1'b0, 1'b1);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_cnt", strobe_q.size(), 1);
        check("glitch_num", (strobe_q.size() > 0) ? strobe_q[0] % 64 : -1, 5);

        // Reset in the middle of a frame.
        part = 8'h5A;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(part[i], 1'b0);
        rst_i = 1'b0;
        wait_cyc(3);
        #1;
        check_reset_outputs("midrst");
        bus.ps2_dat = 1'b1;
        bus.ps2_clk = 1'b1;
        wait_cyc(5);
        rst_i = 1'b1;
        wait_cyc(40);
        key_event(1'b0, 1'b0, 8'h29, "space_after_rst");

        // Randomised key events, half drawn from the mapped set.
        for (int n = 0; n < 30; n++) begin
            ext = ($urandom_range(0, 3) == 0);
            brk = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                code = zx_rows[$urandom_range(0, 7)][$urandom_range(0, 4)];
            end else begin
                do code = 8'($urandom_range(1, 254)); while (is_special(code));
            end
            key_event(ext, brk, code, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zx_ps2_scan_decoder.md
Name: zx_ps2_scan_decoder

Overview:
- Upstream stage of the ZX key-matrix block. Receives raw PS/2 keyboard frames, assembles scan-code set 2 sequences (E0/F0/E1 prefixes) and translates each make/break into a key command.
- Key command: key index 0..41 in the ZX matrix numbering (0..39 matrix keys, 40 magic, 41 Z80 reset) plus a released flag. It is issued as a one-cycle strobe toward the matrix-update logic.

Parameters:
- FILTER_LEN, 8: clk_50M cycles a PS/2 line must be stable before its filtered level changes.
- TIMEOUT_CYC, 50000: idle cycles (1 ms at 50 MHz) allowed between falling edges inside a frame before the frame is abandoned.

Ports:
- clk_50M  input  1  system clock, 50 MHz
- rst_i  input  1  asynchronous active-low reset
- ps2_clk  input  1  PS/2 clock line, asynchronous to clk_50M
- ps2_dat  input  1  PS/2 data line, asynchronous to clk_50M
- key_num  output  6  ZX key index of the last command, 0..41
- key_rel  output  1  1 = key released, 0 = key pressed
- key_stb  output  1  one-cycle pulse; key_num/key_rel valid in that cycle and held until the next pulse
- frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset (rst_i = 0, asynchronous): key_num = 0, key_rel = 1, key_stb = 0, frame_err = 0. Frame state machine goes to IDLE and all prefix flags clear. Reset mid-frame discards the partial frame.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then a stability filter.
  - The filter changes its output only after FILTER_LEN consecutive identical synchronised samples.
  - A PS/2 clock edge is a 1-to-0 transition of the filtered clock. Filtered data is sampled in that cycle.
- Frame state machine:
  - IDLE: on an edge, data must be 0 (start bit), then go to DATA. If data is 1, raise frame_err and stay in IDLE.
  - DATA: 8 edges shift bits in LSB first, then go to PARITY.
  - PARITY: the sampled bit must make the XOR of 8 data bits plus parity equal 1 (odd parity). Go to STOP.
  - STOP: the sampled bit must be 1 and parity must be good; then deliver the byte to the sequence decoder with a 1-cycle internal pulse. Otherwise raise frame_err. Return to IDLE in either case.
  - Timeout: in DATA, PARITY or STOP, if TIMEOUT_CYC cycles pass without an edge, raise frame_err and return to IDLE. The counter restarts on every edge.
- Sequence decoder, for each delivered byte:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - 0xE1: load skip counter = 7. The next 7 bytes are consumed silently and flags are cleared (Pause key ignored).
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: ignored, flags cleared.
  - Any other code: look up {ext, code}.
    - If mapped: key_num = index, key_rel = brk, key_stb = 1 for exactly one cycle, in the cycle after the STOP-bit byte pulse.
    - If unmapped: no strobe.
    - ext and brk clear in both cases.
  - A frame error clears ext, brk and the skip counter.
- Map (set-2 make codes, non-ext unless noted):
  - Letters and digits map to their ZX matrix index, e.g. Z 0x1A -> 8, A 0x1C -> 1, Q 0x15 -> 2, 1 0x16 -> 3, 0 0x45 -> 4, P 0x4D -> 5, B 0x32 -> 39.
  - Left Shift 0x12 -> 0 (CS).
  - Right Shift 0x59 -> 15 (SS).
  - Left Ctrl 0x14 -> 15 (SS).
  - Enter 0x5A -> 6; ext Enter (E0 5A) -> 6.
  - Space 0x29 -> 7.
  - F12 0x07 -> 40 (magic).
  - F10 0x09 -> 41 (reset).
  - Everything else is unmapped.
- Typematic repeats (repeated make with no break) each produce a fresh strobe with key_rel = 0.
- Throughput: at most one strobe per PS/2 byte. There is no back-pressure; the downstream block must accept a strobe every cycle.

Test Plan:
- Valid frame for 0x1A (start 0, bits 01011000, parity 0, stop 1) at 12.5 kHz -> key_stb once, key_num = 8, key_rel = 0.
- Sequence F0 1A -> a single strobe with key_num = 8, key_rel = 1; no strobe is produced for the F0 byte itself.
- Frame 0x1C with the parity bit flipped -> frame_err pulse and no key_stb; a following good 0x1C -> key_num = 1, key_rel = 0.
- Stop clocking after 4 data bits for more than 50000 cycles -> one frame_err pulse. Next full frame 0x07 -> key_num = 40, key_rel = 0.
- Byte sequence E1 14 77 E1 F0 14 F0 77, then 0x09 -> no strobes during the first 8 bytes; 0x09 -> key_num = 41, key_rel = 0.
- Glitch pulses on ps2_clk shorter than 8 cycles -> no bit sampled. Assert rst_i mid-frame -> outputs return to reset values, and a following clean frame 0x29 -> key_num = 7.
